sync_fifo_prog: RTL and testbench
=================================

// Module: sync_fifo_prog
// PURPOSE
// - Parametrised single-clock FIFO. Next generation of the fixed-size FIFO used under the FIFO_IF bench.
// - Adds generic width/depth, run-time programmable almost-full/almost-empty thresholds and an occupancy output.
// - Optional first-word-fall-through (FWFT) read mode.
// - Drop-in for the existing FIFO port set, plus af_thresh, ae_thresh and count.
// PARAMETERS
// - DATA_WIDTH  16  width of data_in/data_out in bits.
// - DEPTH       8   number of entries; power of 2, >= 4.
// - AW          $clog2(DEPTH)  derived pointer width; do not override.
// PORTS
// - clk          in   1       single clock; all state updates on rising edge.
// - rst_n        in   1       asynchronous, active-low reset.
// - data_in      in   DATA_WIDTH  write data.
// - wr_en        in   1       write request.
// - rd_en        in   1       read request.
// - af_thresh    in   AW+1    almost-full threshold (entries).
// - ae_thresh    in   AW+1    almost-empty threshold (entries).
// - data_out     out  DATA_WIDTH  read data.
// - full         out  1       count == DEPTH.
// - empty        out  1       count == 0.
// - almostfull   out  1       count >= af_thresh.
// - almostempty  out  1       count <= ae_thresh.
// - wr_ack       out  1       registered; write accepted last cycle.
// - overflow     out  1       registered; write rejected (full) last cycle.
// - underflow    out  1       registered; read rejected (empty) last cycle.
// - count        out  AW+1    current occupancy, 0..DEPTH.
// BEHAVIOUR
// - Storage: wr_ptr and rd_ptr are AW bits each and wrap modulo DEPTH. count is a separate AW+1-bit counter.
// - Accept rules use the flags sampled in the current cycle:
//   - wr_acc = wr_en & ~full
//   - rd_acc = rd_en & ~empty
//   - count' = count + wr_acc - rd_acc
// - Full with wr_en & rd_en: the read is accepted, the write is rejected, overflow=1 next cycle, count becomes DEPTH-1.
// - Empty with wr_en & rd_en: the write is accepted, the read is rejected, underflow=1 next cycle, count becomes 1.
// - Neither flag set with wr_en & rd_en: both are accepted and count is unchanged.
// - wr_ack, overflow and underflow are single-cycle pulses, registered one cycle after the request; they are 0 when there is no request.
// - full, empty, almostfull and almostempty are combinational decodes of count.
// - Threshold ports are compared as unsigned values:
//   - af_thresh = 0 forces almostfull = 1.
//   - ae_thresh >= DEPTH forces almostempty = 1.
// - Standard mode: data_out is registered and loads mem[rd_ptr] on the edge of rd_acc (1-cycle read latency). It holds its value otherwise.
// - Reset (async assert, sync release): ptrs=0, count=0, data_out=0, wr_ack=overflow=underflow=0.
//   - Resulting flags: empty=1, full=0, almostempty=1, almostfull=(af_thresh==0).
//   - Reset mid-operation discards all contents. Memory array is not cleared.
// CONFIGURATION
// - Macro SYNC_FIFO_PROG_FWFT_EN:
//   - Defined: data_out = mem[rd_ptr] combinationally whenever ~empty; rd_acc pops and the next word appears the same cycle after the edge.
//   - Defined, empty: data_out holds the last popped word, or 0 after reset.
//   - Defined: a write into an empty FIFO is visible on data_out the cycle after the write edge.
//   - Undefined: standard registered-read mode as above.
//   - Flags, count and pulses are identical in both modes.
// STRUCTURE
// - Package fifo_pkg holds:
//   - typedef fifo_flags_t: packed struct {full, empty, almostfull, almostempty}.
//   - function clog2_safe.
//   - localparams DEF_DATA_WIDTH=16, DEF_DEPTH=8.
// - Sub-module fifo_mem: DEPTH x DATA_WIDTH array with synchronous write (we, waddr, wdata) and combinational read (raddr, rdata).
// - Top holds pointers, count, flags and output register.
// TESTING
// - Settings for all scenarios: DATA_WIDTH=16, DEPTH=8, af_thresh=6, ae_thresh=2, standard mode unless stated.
// - 1. Reset, then write 0x0001..0x0008 over 8 cycles:
//   - wr_ack=1 each following cycle.
//   - count 1..8; almostfull at count=6; full at 8.
//   - 9th write gives overflow=1 and wr_ack=0; count stays 8.
// - 2. Read 8 times:
//   - data_out = 0x0001..0x0008, each 1 cycle after rd_en.
//   - almostempty at count=2; empty at 0.
//   - 9th read gives underflow=1; data_out holds 0x0008.
// - 3. Full FIFO, wr_en=rd_en=1 for one cycle:
//   - count goes to 7, overflow=1, wr_ack=0.
//   - data_out = oldest word.
// - 4. Empty FIFO, wr_en=rd_en=1 with data 0xBEEF:
//   - count=1, wr_ack=1, underflow=1.
//   - Next read returns 0xBEEF.
// - 5. Count=4, rd/wr both for 20 cycles with an incrementing pattern:
//   - count stays 4.
//   - Output order matches input order across pointer wrap.
// - 6. Set rst_n=0 mid-stream at count=5, asynchronously between edges:
//   - Immediately count=0, empty=1, wr_ack/overflow/underflow=0, data_out=0.
// - 7. With SYNC_FIFO_PROG_FWFT_EN, write 0x00A5 to an empty FIFO:
//   - The next cycle data_out=0x00A5 with no rd_en.
//   - rd_en pops it and empty=1.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types, defaults and helpers for the programmable single-clock FIFO.
// Used by fifo_mem, sync_fifo_prog_if and sync_fifo_prog.
package fifo_pkg;

    localparam int DEF_DATA_WIDTH = 32'sd16;
    localparam int DEF_DEPTH      = 32'sd8;

    typedef struct packed {
        logic full;
        logic empty;
        logic almostfull;
        logic almostempty;
    } fifo_flags_t;

    // Ceiling log2 that never returns less than 1, so a pointer always has a bit.
    function automatic int clog2_safe(input int value);
        int r;
        r = 32'sd0;
        for (int i = 0; i < 32'sd31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                r = i + 32'sd1;
            end else begin
                r = r;
            end
        end
        if (r < 32'sd1) begin
            r = 32'sd1;
        end else begin
            r = r;
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo_prog_if.sv
// Handshake/data/status bundle between a FIFO user (master) and sync_fifo_prog (slave).
interface sync_fifo_prog_if
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int AW         = clog2_safe(DEPTH)
);
    logic [DATA_WIDTH-1:0] data_in;
    logic                  wr_en;
    logic                  rd_en;
    logic [AW:0]           af_thresh;
    logic [AW:0]           ae_thresh;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  full;
    logic                  empty;
    logic                  almostfull;
    logic                  almostempty;
    logic                  wr_ack;
    logic                  overflow;
    logic                  underflow;
    logic [AW:0]           count;

    modport master (
        output data_in, wr_en, rd_en, af_thresh, ae_thresh,
        input  data_out, full, empty, almostfull, almostempty,
               wr_ack, overflow, underflow, count
    );

    modport slave (
        input  data_in, wr_en, rd_en, af_thresh, ae_thresh,
        output data_out, full, empty, almostfull, almostempty,
               wr_ack, overflow, underflow, count
    );
endinterface

// File: rtl/fifo_mem.sv
// DEPTH x DATA_WIDTH storage: synchronous write port, combinational read port.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int AW         = clog2_safe(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];

    // Array write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/sync_fifo_prog.sv
// Parametrised single-clock FIFO with programmable almost-full/almost-empty thresholds.
// Define SYNC_FIFO_PROG_FWFT_EN for first-word-fall-through reads; default is registered read.
module sync_fifo_prog
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int AW         = clog2_safe(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    sync_fifo_prog_if.slave  bus
);

    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    logic [AW-1:0]         wr_ptr_r;
    logic [AW-1:0]         rd_ptr_r;
    logic [AW:0]           count_r;
    logic [AW:0]           count_nxt_s;
    logic [DATA_WIDTH-1:0] data_out_r;
    logic [DATA_WIDTH-1:0] rdata_s;
    logic                  wr_ack_r;
    logic                  overflow_r;
    logic                  underflow_r;
    logic                  wr_acc_s;
    logic                  rd_acc_s;
    fifo_flags_t           flags_s;

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (AW)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc_s),
        .waddr (wr_ptr_r),
        .wdata (bus.data_in),
        .raddr (rd_ptr_r),
        .rdata (rdata_s)
    );

    // Status flags decoded from occupancy; thresholds compare unsigned.
    always_comb begin
        flags_s             = '0;
        flags_s.full        = (count_r == DEPTH_C);
        flags_s.empty       = (count_r == '0);
        flags_s.almostfull  = (count_r >= bus.af_thresh);
        flags_s.almostempty = (count_r <= bus.ae_thresh);
    end

    // Accept decisions and next occupancy from the current-cycle flags.
    always_comb begin
        wr_acc_s    = bus.wr_en & ~flags_s.full;
        rd_acc_s    = bus.rd_en & ~flags_s.empty;
        count_nxt_s = count_r;
        case ({wr_acc_s, rd_acc_s})
            2'b10:   count_nxt_s = count_r + {{AW{1'b0}}, 1'b1};
            2'b01:   count_nxt_s = count_r - {{AW{1'b0}}, 1'b1};
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointers, occupancy, handshake pulses and the read-data register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            count_r     <= '0;
            data_out_r  <= '0;
            wr_ack_r    <= 1'b0;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            count_r     <= count_nxt_s;
            wr_ack_r    <= wr_acc_s;
            overflow_r  <= bus.wr_en & flags_s.full;
            underflow_r <= bus.rd_en & flags_s.empty;
            if (wr_acc_s) begin
                wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            // In FWFT mode this register keeps the last popped word for the empty case.
            if (rd_acc_s) begin
                rd_ptr_r   <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
                data_out_r <= rdata_s;
            end
        end
    end

`ifdef SYNC_FIFO_PROG_FWFT_EN
    assign bus.data_out = flags_s.empty ? data_out_r : rdata_s;
`else
    assign bus.data_out = data_out_r;
`endif

    assign bus.full        = flags_s.full;
    assign bus.empty       = flags_s.empty;
    assign bus.almostfull  = flags_s.almostfull;
    assign bus.almostempty = flags_s.almostempty;
    assign bus.wr_ack      = wr_ack_r;
    assign bus.overflow    = overflow_r;
    assign bus.underflow   = underflow_r;
    assign bus.count       = count_r;

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Scoreboard bench for sync_fifo_prog (DATA_WIDTH=16, DEPTH=8); honours SYNC_FIFO_PROG_FWFT_EN.
module tb_sync_fifo_prog;

    logic clk;
    logic rst_n;

    sync_fifo_prog_if #(.DATA_WIDTH(16), .DEPTH(8)) bus ();

    sync_fifo_prog #(.DATA_WIDTH(16), .DEPTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_compared;
    int          n_mismatched;
    logic [15:0] sb_q [$];
    int          m_cnt;
    logic [15:0] m_last;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_compared++;
        if (obs !== expv) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic check_outputs(input logic e_ack, input logic e_ovf, input logic e_unf);
        logic [15:0] e_dout;
`ifdef SYNC_FIFO_PROG_FWFT_EN
        e_dout = (sb_q.size() != 0) ? sb_q[0] : m_last;
`else
        e_dout = m_last;
`endif
        check_val("count",       32'(bus.count),       32'(m_cnt));
        check_val("full",        32'(bus.full),        32'(m_cnt == 8));
        check_val("empty",       32'(bus.empty),       32'(m_cnt == 0));
        check_val("almostfull",  32'(bus.almostfull),  32'(m_cnt >= int'(bus.af_thresh)));
        check_val("almostempty", 32'(bus.almostempty), 32'(m_cnt <= int'(bus.ae_thresh)));
        check_val("wr_ack",      32'(bus.wr_ack),      32'(e_ack));
        check_val("overflow",    32'(bus.overflow),    32'(e_ovf));
        check_val("underflow",   32'(bus.underflow),   32'(e_unf));
        check_val("data_out",    32'(bus.data_out),    32'(e_dout));
    endtask

    // One clock: drive at falling edge, predict, sample 1 time unit after rising edge.
    task automatic do_cycle(input logic wr, input logic rd, input logic [15:0] d);
        logic wacc;
        logic racc;
        @(negedge clk);
        wacc = wr && (m_cnt != 8);
        racc = rd && (m_cnt != 0);
        bus.wr_en   = wr;
        bus.rd_en   = rd;
        bus.data_in = d;
        @(posedge clk);
        #1;
        if (racc) m_last = sb_q.pop_front();
        if (wacc) sb_q.push_back(d);
        m_cnt = m_cnt + int'(wacc) - int'(racc);
        check_outputs(wacc, wr && !wacc, rd && !racc);
    endtask

    task automatic model_reset();
        sb_q.delete();
        m_cnt  = 0;
        m_last = 16'h0000;
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        model_reset();
        bus.wr_en     = 1'b0;
        bus.rd_en     = 1'b0;
        bus.data_in   = 16'h0000;
        bus.af_thresh = 4'd6;
        bus.ae_thresh = 4'd2;
        rst_n         = 1'b0;
        #1;
        check_outputs(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: fill with 1..8, then one rejected write
        for (int i = 1; i <= 8; i++) do_cycle(1'b1, 1'b0, 16'(i));
        do_cycle(1'b1, 1'b0, 16'h0009);

        // 2: drain, then one rejected read
        for (int i = 0; i < 9; i++) do_cycle(1'b0, 1'b1, 16'h0000);
        check_val("hold_last", 32'(bus.data_out), 32'h0008);

        // 3: simultaneous read/write while full
        for (int i = 0; i < 8; i++) do_cycle(1'b1, 1'b0, 16'h0010 + 16'(i));
        do_cycle(1'b1, 1'b1, 16'h0077);
        check_val("full_rw_dout", 32'(bus.data_out), 32'h0010);

        // 4: drain, then simultaneous read/write while empty
        for (int i = 0; i < 7; i++) do_cycle(1'b0, 1'b1, 16'h0000);
        do_cycle(1'b1, 1'b1, 16'hBEEF);
        do_cycle(1'b0, 1'b1, 16'h0000);
        check_val("beef_read", 32'(bus.data_out), 32'h0000BEEF);

        // 5: steady-state streaming at count=4 across pointer wrap
        for (int i = 0; i < 4; i++) do_cycle(1'b1, 1'b0, 16'h0100 + 16'(i));
        for (int i = 4; i < 24; i++) do_cycle(1'b1, 1'b1, 16'h0100 + 16'(i));
        check_val("stream_count", 32'(bus.count), 32'd4);
        for (int i = 0; i < 4; i++) do_cycle(1'b0, 1'b1, 16'h0000);

        // 6: asynchronous reset at count=5, between clock edges
        for (int i = 0; i < 5; i++) do_cycle(1'b1, 1'b0, 16'h0200 + 16'(i));
        do_cycle(1'b0, 1'b1, 16'h0000);
        do_cycle(1'b1, 1'b0, 16'h0300);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs(1'b0, 1'b0, 1'b0);
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // threshold boundaries: af=0 forces almostfull, ae>=DEPTH forces almostempty
        bus.af_thresh = 4'd0;
        bus.ae_thresh = 4'd8;
        do_cycle(1'b0, 1'b0, 16'h0000);
        for (int i = 0; i < 8; i++) do_cycle(1'b1, 1'b0, 16'h0400 + 16'(i));
        bus.af_thresh = 4'd9;
        bus.ae_thresh = 4'd7;
        do_cycle(1'b0, 1'b1, 16'h0000);
        do_cycle(1'b0, 1'b1, 16'h0000);
        bus.af_thresh = 4'd6;
        bus.ae_thresh = 4'd2;
        for (int i = 0; i < 6; i++) do_cycle(1'b0, 1'b1, 16'h0000);

`ifdef SYNC_FIFO_PROG_FWFT_EN
        // 7: first-word-fall-through visibility and pop
        do_cycle(1'b1, 1'b0, 16'h00A5);
        check_val("fwft_visible", 32'(bus.data_out), 32'h00A5);
        do_cycle(1'b0, 1'b1, 16'h0000);
        check_val("fwft_empty", 32'(bus.empty), 32'd1);
`endif

        do_cycle(1'b0, 1'b0, 16'h0000);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
